// File: rtl/instr_fetch.sv
// Instruction fetch unit: assembles big-endian 32-bit words from a byte-wide
// instruction memory (one byte per cycle) and queues them with their byte
// address. A redirect input flushes the queue and restarts fetching.
// Optional feature macro FETCH_PREDECODE_EN: j/jal opcodes in a pushed word
// steer the next fetch address, and the entry is tagged pred_taken.
module instr_fetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [7:0]  RESET_PC = 8'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [7:0]  mem_addr,
   input  logic [7:0]  mem_data,
   output logic [31:0] instr,
   output logic [7:0]  instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic [3:0]  fifo_count,
   output logic        pred_taken
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

   typedef enum logic {ST_ASM, ST_WAIT} state_e;

   state_e        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [7:0]    fetch_pc_q, fetch_pc_d;
   logic [23:0]   buf_q, buf_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]    count_q, count_d;
   logic [7:0]    qpc_q   [DEPTH];
   logic [7:0]    qpc_d   [DEPTH];
   logic [31:0]   qword_q [DEPTH];
   logic [31:0]   qword_d [DEPTH];
`ifdef FETCH_PREDECODE_EN
   logic          qpred_q [DEPTH];
   logic          qpred_d [DEPTH];
   logic          is_jump;
`endif

   logic          assembling;
   logic          push;
   logic          pop;
   logic [31:0]   word;
   logic [7:0]    next_pc;

   assign instr_valid = (count_q != 4'd0);
   assign mem_addr    = fetch_pc_q + {6'b0, cnt_q};
   assign fifo_count  = count_q;
   assign instr       = instr_valid ? qword_q[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? qpc_q[rd_ptr_q] : '0;
`ifdef FETCH_PREDECODE_EN
   assign pred_taken  = instr_valid ? qpred_q[rd_ptr_q] : 1'b0;
`else
   assign pred_taken  = 1'b0;
`endif

   // Next-state: byte assembly, queue push/pop and redirect flush
   always_comb begin
      // A WAIT cycle with room in the queue doubles as the cnt=0 byte read,
      // so assembly resumes in the very cycle after a pop frees a slot.
      assembling = (state_q == ST_ASM) || (count_q < DEPTH_C);
      word       = {buf_q, mem_data};
      push       = assembling && (cnt_q == 2'd3) && !redirect;
      pop        = instr_valid && instr_ready && !redirect;
`ifdef FETCH_PREDECODE_EN
      is_jump    = (word[31:26] == 6'b010101) || (word[31:26] == 6'b010110);
      next_pc    = is_jump ? {word[5:0], 2'b00} : fetch_pc_q + 8'd4;
`else
      next_pc    = fetch_pc_q + 8'd4;
`endif
      state_d    = state_q;
      cnt_d      = cnt_q;
      fetch_pc_d = fetch_pc_q;
      buf_d      = buf_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      qpc_d      = qpc_q;
      qword_d    = qword_q;
`ifdef FETCH_PREDECODE_EN
      qpred_d    = qpred_q;
`endif
      if (redirect) begin
         state_d    = ST_ASM;
         cnt_d      = 2'd0;
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = 4'd0;
      end else begin
         if (assembling) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
               2'd0:    buf_d[23:16] = mem_data;
               2'd1:    buf_d[15:8]  = mem_data;
               2'd2:    buf_d[7:0]   = mem_data;
               default: buf_d        = buf_q;
            endcase
         end
         if (push) begin
            qpc_d[wr_ptr_q]   = fetch_pc_q;
            qword_d[wr_ptr_q] = word;
`ifdef FETCH_PREDECODE_EN
            qpred_d[wr_ptr_q] = is_jump;
`endif
            wr_ptr_d          = wr_ptr_q + 1'b1;
            fetch_pc_d        = next_pc;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + {3'b0, push} - {3'b0, pop};
         if (push && (count_d == DEPTH_C)) begin
            state_d = ST_WAIT;
         end else if (assembling) begin
            state_d = ST_ASM;
         end else begin
            state_d = ST_WAIT;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_ASM;
         cnt_q      <= 2'd0;
         fetch_pc_q <= RESET_PC;
         buf_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= 4'd0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            qpc_q[i]   <= '0;
            qword_q[i] <= '0;
`ifdef FETCH_PREDECODE_EN
            qpred_q[i] <= 1'b0;
`endif
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fetch_pc_q <= fetch_pc_d;
         buf_q      <= buf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         qpc_q      <= qpc_d;
         qword_q    <= qword_d;
`ifdef FETCH_PREDECODE_EN
         qpred_q    <= qpred_d;
`endif
      end
   end

endmodule
